// File: rtl/burst_rd_pkg.sv
// Shared types and helpers for the burst read controller.
package burst_rd_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_DLY  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   // The length field must hold MAX_BURST itself, so one bit beyond the index width.
   function automatic int len_width(input int max_burst);
      return $clog2(max_burst) + 1;
   endfunction

endpackage

// File: rtl/burst_rd_fsm.sv
// Burst read controller: issues len read strobes at incrementing addresses,
// with optional inter-beat delay, wait-state hold, abort and a done strobe.
module burst_rd_fsm
   import burst_rd_pkg::*;
#(
   parameter int MAX_BURST = 16,
   parameter int DLY       = 1,
   parameter int ADDR_W    = 8,
   parameter int LEN_W     = len_width(MAX_BURST)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              go,
   input  logic [LEN_W-1:0]  len,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              ws,
   input  logic              abort,
   output logic              rd,
   output logic [ADDR_W-1:0] addr,
   output logic              ds,
   output logic              aborted,
   output logic              busy,
   output logic [LEN_W-1:0]  beats_done
);

   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BURST);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] base_q;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  beats_q;
   logic [LEN_W-1:0]  beats_inc;
   logic [LEN_W-1:0]  len_eff;
   logic              aborted_q;
   logic              go_accept;
   logic              beat_fire;
   logic              abort_fire;
   logic              dly_last;

   assign len_eff   = (len > MAX_LEN) ? MAX_LEN : len;
   assign beats_inc = beats_q + 1'b1;

   // NOTE: every signal written here gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      go_accept  = 1'b0;
      beat_fire  = 1'b0;
      abort_fire = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (go) begin
               go_accept = 1'b1;
               state_d   = (len_eff == '0) ? S_DONE : S_READ;
            end
         end
         S_READ: begin
            // A beat that completes alongside abort still counts.
            beat_fire = !ws;
            if (abort) begin
               abort_fire = 1'b1;
               state_d    = S_DONE;
            end else if (!ws) begin
               if (DLY > 0)
                  state_d = S_DLY;
               else
                  state_d = (beats_inc < len_q) ? S_READ : S_DONE;
            end
         end
         S_DLY: begin
            if (abort) begin
               abort_fire = 1'b1;
               state_d    = S_DONE;
            end else if (dly_last) begin
               state_d = (beats_q < len_q) ? S_READ : S_DONE;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         base_q    <= '0;
         len_q     <= '0;
         beats_q   <= '0;
         aborted_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (go_accept) begin
            base_q    <= base_addr;
            len_q     <= len_eff;
            beats_q   <= '0;
            aborted_q <= 1'b0;
         end
         if (beat_fire)
            beats_q <= beats_inc;
         if (abort_fire)
            aborted_q <= 1'b1;
      end
   end

   generate
      if (DLY > 0) begin : g_dly
         localparam int DW = $clog2(DLY + 1);
         localparam logic [DW-1:0] DLY_INIT = DW'(DLY - 1);
         logic [DW-1:0] dly_q;

         // Loaded as a beat completes, so the DLY state lasts exactly DLY cycles.
         always_ff @(posedge clk) begin
            if (rst)
               dly_q <= '0;
            else if (beat_fire)
               dly_q <= DLY_INIT;
            else if (state_q == S_DLY && dly_q != '0)
               dly_q <= dly_q - 1'b1;
         end

         assign dly_last = (dly_q == '0);
      end else begin : g_no_dly
         assign dly_last = 1'b1;
      end
   endgenerate

   assign rd         = (state_q == S_READ);
   assign addr       = rd ? (base_q + ADDR_W'(beats_q)) : '0;
   assign ds         = (state_q == S_DONE);
   assign busy       = (state_q != S_IDLE);
   assign aborted    = aborted_q;
   assign beats_done = beats_q;

endmodule

// File: tb/tb_burst_rd_fsm.sv
// Self-checking bench: two controllers (DLY=1 and DLY=0) share one stimulus;
// expected per-cycle outputs are derived from the beat timing formulas.
module tb_burst_rd_fsm;

   logic       clk;
   logic       rst;
   logic       go;
   logic [4:0] len;
   logic [7:0] base_addr;
   logic       ws;
   logic       abort;

   logic       rd1, ds1, ab1, busy1;
   logic [7:0] addr1;
   logic [4:0] bd1;
   logic       rd0, ds0, ab0, busy0;
   logic [7:0] addr0;
   logic [4:0] bd0;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      bit         sel;     // 1: DLY=1 instance, 0: DLY=0 instance
      logic [4:0] len;
      logic [7:0] base;
      int         ws_n;    // wait-state cycles applied to beat 0
      int         exp_n;   // expected completed beats
   } vec_t;

   typedef struct {
      logic       rd;
      logic [7:0] addr;
      logic       ds;
      logic       busy;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[9];

   burst_rd_fsm u_dly1 (
      .clk(clk), .rst(rst), .go(go), .len(len), .base_addr(base_addr),
      .ws(ws), .abort(abort), .rd(rd1), .addr(addr1), .ds(ds1),
      .aborted(ab1), .busy(busy1), .beats_done(bd1)
   );

   burst_rd_fsm #(.DLY(0)) u_dly0 (
      .clk(clk), .rst(rst), .go(go), .len(len), .base_addr(base_addr),
      .ws(ws), .abort(abort), .rd(rd0), .addr(addr0), .ds(ds0),
      .aborted(ab0), .busy(busy0), .beats_done(bd0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         if (!busy0 && !busy1)
            break;
         tick();
      end
      check("idle_timeout", 32'(busy0 | busy1), 32'd0);
   endtask

   // Called #1 after a rising edge with both instances idle.
   task automatic run_burst(input bit sel, input logic [4:0] l, input logic [7:0] b,
                            input int ws_n, input int exp_n);
      int   d;
      int   s;
      int   t_ds;
      int   rel;
      exp_t e;
      logic s_rd, s_ds, s_busy, s_ab;
      logic [7:0] s_addr;
      logic [4:0] s_bd;

      d    = sel ? 1 : 0;
      s    = (exp_n > 0) ? ws_n : 0;
      t_ds = 1 + exp_n * (1 + d) + s;

      go        = 1'b1;
      len       = l;
      base_addr = b;
      for (int t = 1; t <= t_ds + 1; t++) begin
         e.rd   = 1'b0;
         e.addr = 8'h00;
         e.ds   = (t == t_ds);
         e.busy = (t <= t_ds);
         if (t < t_ds && exp_n > 0) begin
            if (t <= 1 + s) begin
               e.rd   = 1'b1;
               e.addr = b;
            end else begin
               rel = t - 1 - s;
               if (rel % (1 + d) == 0) begin
                  e.rd   = 1'b1;
                  e.addr = b + 8'(rel / (1 + d));
               end
            end
         end
         sb.push_back(e);
      end

      tick();
      go = 1'b0;
      for (int t = 1; t <= t_ds + 1; t++) begin
         ws = (t <= s);
         @(negedge clk);
         e      = sb.pop_front();
         s_rd   = sel ? rd1   : rd0;
         s_addr = sel ? addr1 : addr0;
         s_ds   = sel ? ds1   : ds0;
         s_busy = sel ? busy1 : busy0;
         s_ab   = sel ? ab1   : ab0;
         s_bd   = sel ? bd1   : bd0;
         check($sformatf("rd[len=%0d,t=%0d]", l, t), 32'(s_rd), 32'(e.rd));
         check($sformatf("ds[len=%0d,t=%0d]", l, t), 32'(s_ds), 32'(e.ds));
         check($sformatf("busy[len=%0d,t=%0d]", l, t), 32'(s_busy), 32'(e.busy));
         if (e.rd)
            check($sformatf("addr[len=%0d,t=%0d]", l, t), 32'(s_addr), 32'(e.addr));
         if (e.ds) begin
            check("aborted_at_ds", 32'(s_ab), 32'd0);
            check($sformatf("beats_done[len=%0d]", l), 32'(s_bd), 32'(exp_n));
         end
         tick();
      end
      ws = 1'b0;
      s_bd = sel ? bd1 : bd0;
      check($sformatf("beats_hold[len=%0d]", l), 32'(s_bd), 32'(exp_n));
      wait_idle();
   endtask

   initial begin
      vecs[0] = '{sel: 1'b1, len: 5'd4,  base: 8'h10, ws_n: 0, exp_n: 4};
      vecs[1] = '{sel: 1'b0, len: 5'd3,  base: 8'h20, ws_n: 0, exp_n: 3};
      vecs[2] = '{sel: 1'b1, len: 5'd2,  base: 8'h30, ws_n: 2, exp_n: 2};
      vecs[3] = '{sel: 1'b1, len: 5'd0,  base: 8'h40, ws_n: 0, exp_n: 0};
      vecs[4] = '{sel: 1'b1, len: 5'd31, base: 8'h50, ws_n: 0, exp_n: 16};
      vecs[5] = '{sel: 1'b1, len: 5'd4,  base: 8'hFE, ws_n: 0, exp_n: 4};
      vecs[6] = '{sel: 1'b0, len: 5'd16, base: 8'hF8, ws_n: 1, exp_n: 16};
      vecs[7] = '{sel: 1'b0, len: 5'd0,  base: 8'h00, ws_n: 0, exp_n: 0};
      vecs[8] = '{sel: 1'b0, len: 5'd20, base: 8'hC0, ws_n: 0, exp_n: 16};

      rst = 1'b1; go = 1'b0; len = '0; base_addr = '0; ws = 1'b0; abort = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check("rst_rd",    32'({rd1, rd0}),     32'd0);
      check("rst_ds",    32'({ds1, ds0}),     32'd0);
      check("rst_ab",    32'({ab1, ab0}),     32'd0);
      check("rst_busy",  32'({busy1, busy0}), 32'd0);
      check("rst_bd",    32'({bd1, bd0}),     32'd0);
      check("rst_addr",  32'({addr1, addr0}), 32'd0);
      tick();
      rst = 1'b0;
      tick();

      for (int i = 0; i < 9; i++)
         run_burst(vecs[i].sel, vecs[i].len, vecs[i].base, vecs[i].ws_n, vecs[i].exp_n);

      // Abort: DLY=1 instance is in DLY after beat 1, DLY=0 instance is mid-READ.
      go = 1'b1; len = 5'd8; base_addr = 8'h60;        // cycle 0
      tick(); go = 1'b0;                               // cycle 1
      tick(); tick(); tick();                          // cycle 4
      abort = 1'b1;
      @(negedge clk);
      check("abort_pre_rd1",   32'(rd1),   32'd0);
      check("abort_pre_busy1", 32'(busy1), 32'd1);
      tick(); abort = 1'b0; go = 1'b1; len = 5'd2; base_addr = 8'h70;  // cycle 5, DONE
      @(negedge clk);
      check("abort_ds1",  32'(ds1), 32'd1);
      check("abort_ab1",  32'(ab1), 32'd1);
      check("abort_bd1",  32'(bd1), 32'd2);
      check("abort_ds0",  32'(ds0), 32'd1);
      check("abort_ab0",  32'(ab0), 32'd1);
      check("abort_bd0",  32'(bd0), 32'd4);
      tick(); go = 1'b0; abort = 1'b1;                 // cycle 6, idle abort ignored
      @(negedge clk);
      check("go_in_done_busy", 32'({busy1, busy0}), 32'd0);
      check("ab_held",         32'(ab1), 32'd1);
      check("bd_held",         32'(bd1), 32'd2);
      tick(); abort = 1'b0; go = 1'b1;                 // cycle 7
      @(negedge clk);
      check("idle_abort_ds",   32'({ds1, ds0}),     32'd0);
      check("idle_abort_busy", 32'({busy1, busy0}), 32'd0);
      tick(); go = 1'b0;                               // cycle 8
      @(negedge clk);
      check("rego_rd1",   32'(rd1),   32'd1);
      check("rego_addr1", 32'(addr1), 32'h70);
      check("rego_ab1",   32'(ab1),   32'd0);
      check("rego_bd1",   32'(bd1),   32'd0);
      tick();
      wait_idle();

      // Reset mid-READ kills the burst with no done strobe.
      go = 1'b1; len = 5'd8; base_addr = 8'h80;        // cycle 0
      tick(); go = 1'b0;                               // cycle 1
      tick(); tick();                                  // cycle 3
      rst = 1'b1;
      @(negedge clk);
      check("mid_rd1", 32'(rd1), 32'd1);
      check("mid_rd0", 32'(rd0), 32'd1);
      tick(); rst = 1'b0;                              // cycle 4
      @(negedge clk);
      check("kill_rd",   32'({rd1, rd0}),     32'd0);
      check("kill_addr", 32'({addr1, addr0}), 32'd0);
      check("kill_busy", 32'({busy1, busy0}), 32'd0);
      check("kill_bd",   32'({bd1, bd0}),     32'd0);
      check("kill_ab",   32'({ab1, ab0}),     32'd0);
      for (int i = 0; i < 12; i++) begin
         tick();
         @(negedge clk);
         check($sformatf("kill_no_ds[%0d]", i), 32'({ds1, ds0, busy1, busy0}), 32'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/burst_rd_fsm.md
# burst_rd_fsm

Parametrised burst read controller for a simple synchronous memory port. On a `go` request it issues a programmable number of single-cycle read strobes at incrementing addresses, inserts a configurable delay between beats, and honours memory wait states. It signals completion with a one-cycle done strobe and supports abort. It sits between a command source (DMA or host sequencer) and the memory read port, replacing the fixed single-read IDLE/READ/DLY/DONE controller.

## Interface
Parameters:
- `MAX_BURST`, 16: largest burst length in beats, at least 1.
- `DLY`, 1: idle cycles inserted after every read beat; 0 removes the DLY state entirely.
- `ADDR_W`, 8: address width.
- `LEN_W`, `$clog2(MAX_BURST)+1`: width of the length field. Derived; do not override.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `go`  in  1  start request; sampled only in IDLE.
- `len`  in  LEN_W  beat count, sampled with `go`.
- `base_addr`  in  ADDR_W  first address, sampled with `go`.
- `ws`  in  1  memory wait state; when high during READ, the current beat is held.
- `abort`  in  1  terminate the burst; acted on in READ or DLY.
- `rd`  out  1  read strobe.
- `addr`  out  ADDR_W  read address, valid while `rd` is high.
- `ds`  out  1  done strobe, high for one cycle.
- `aborted`  out  1  qualifies `ds`: the burst ended by abort.
- `busy`  out  1  high in every state except IDLE.
- `beats_done`  out  LEN_W  number of completed beats in the current or last burst.

## Operation
- States:
  - IDLE: `go`=1 latches `len` and `base_addr`.
    - Effective length = min(`len`, MAX_BURST).
    - Effective length 0: go to DONE (no `rd`).
    - Otherwise: go to READ.
    - `go`=0: stay in IDLE.
  - READ: `rd`=1, `addr` = latched base + `beats_done` (modulo 2^ADDR_W, wraps silently).
    - `ws`=1: stay in READ, hold `rd` and `addr`; the beat does not count.
    - `ws`=0: the beat completes and `beats_done` increments. Next state:
      - DLY, if DLY>0.
      - READ, if DLY=0 and beats remain.
      - DONE, otherwise.
  - DLY: stay for exactly DLY cycles (internal down-counter), then go to READ if beats remain, otherwise DONE.
  - DONE: `ds`=1 for one cycle, then IDLE.
- Abort:
  - `abort`=1 in READ or DLY forces DONE next cycle with `aborted`=1. `aborted` stays valid until the next accepted `go`.
  - A READ beat with `abort`=1 and `ws`=0 still counts.
  - Abort has priority over `ws`.
  - `abort` in IDLE or DONE is ignored.
- `go` outside IDLE is ignored. `go` in the DONE cycle is not accepted; it is accepted in IDLE on the following cycle.
- `beats_done` clears on an accepted `go` and holds its final value in IDLE.
- All outputs decode from the registered state and counters only. There is no combinational path from inputs to outputs.

## Timing
- Reset values: state = IDLE, and `rd`, `ds`, `aborted`, `busy`, `beats_done`, `addr` are all 0.
  - `rst` has priority over every input and takes effect mid-burst on the next edge.
  - No `ds` is produced for a burst killed by reset.
- With `go` accepted at cycle 0 and `ws`=0 throughout:
  - Beat k (0-based) has `rd` high at cycle 1 + k·(1+DLY).
  - `ds` is high at cycle 1 + N·(1+DLY).
  - `busy` is high from cycle 1 through the `ds` cycle inclusive.
- Each cycle of `ws`=1 in READ delays all later events by one cycle.
- Effective length 0: `ds` at cycle 1 and `beats_done`=0.

## Structure
- Shared package `burst_rd_pkg`:
  - `state_e` enum: IDLE, READ, DLY, DONE.
  - Helper function for the LEN_W calculation.
- Single module with no sub-module.
  - The beat counter and the delay counter are inline registers.
  - The delay counter is omitted by generate when DLY=0.

## Test plan
- DLY=1, `go` with `len`=4, `base_addr`=0x10 → `rd` at cycles 1, 3, 5, 7 with `addr` 0x10–0x13; `ds`=1 at cycle 9; `beats_done`=4; `aborted`=0.
- DLY=0, `len`=3 → `rd` high continuously at cycles 1–3; `ds` at cycle 4.
- DLY=1, `len`=2, `ws`=1 for 2 cycles on beat 0 → `rd` high at cycles 1–3 holding `addr` base+0; beat 1 at cycle 5; `ds` at cycle 7.
- `len`=0 → `ds` at cycle 1, no `rd`. `len`=31 with MAX_BURST=16 → exactly 16 beats.
- `abort` during DLY after beat 1 of `len`=8 → `ds`=1 and `aborted`=1 the next cycle; `beats_done`=2; `go` accepted 2 cycles later.
- `rst` asserted mid-READ → next cycle all outputs 0, state IDLE, no `ds`. `base_addr`=0xFE, `len`=4 → `addr` sequence 0xFE, 0xFF, 0x00, 0x01.
